// File: rtl/qc_fifo_pkg.sv
// Shared types and width helpers for the QC instruction FIFO family.
package qc_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Index width, kept at least 1 bit so a degenerate depth still elaborates.
  function automatic int idx_w(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/qinst_fifo_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module qinst_fifo_ram #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 38,
  parameter int IW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the indices and count define which words are live.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qinst_fifo.sv
// Instruction FIFO between fetch/decode and issue: any depth, standard or FWFT
// read, occupancy flags, synchronous flush and sticky error flags.
module qinst_fifo
  import qc_fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int DATA_WIDTH    = 38,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int IW = idx_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [IW-1:0] LAST_IDX   = IW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("qinst_fifo: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("qinst_fifo: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("qinst_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [IW-1:0]         wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wa, ra;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  assign wa = wr_en && !full;
  assign ra = rd_en && !empty;

  qinst_fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IW         (IW)
  ) u_ram (
    .clk     (clk),
    .we      (wa && !flush),
    .wr_addr (wr_idx),
    .wr_data (data_in),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wr_idx <= next_idx(wr_idx);
      if (ra) rd_idx <= next_idx(rd_idx);
      if (wa && !ra)      count <= count + 1'b1;
      else if (ra && !wa) count <= count - 1'b1;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_out <= '0;
        valid    <= 1'b0;
      end else if (flush) begin
        data_out <= '0;
        valid    <= 1'b0;
      end else begin
        valid <= ra;
        if (ra) data_out <= rd_data;
      end
    end
  end else begin : g_fwft
    // Head word is presented straight from storage; zero when nothing is held.
    assign valid    = !empty;
    assign data_out = empty ? '0 : rd_data;
  end

endmodule

// File: tb/tb_qinst_fifo.sv
// Directed bench for qinst_fifo: standard DEPTH=5, FWFT DEPTH=4, and DEPTH=8 threshold instances.
module tb_qinst_fifo;

  localparam int DW = 38;

  logic clk;
  logic reset;

  // Instance A: DEPTH=5 standard mode
  logic          a_flush, a_wr, a_rd;
  logic [DW-1:0] a_din, a_dout;
  logic          a_valid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic [2:0]    a_cnt;

  // Instance B: DEPTH=4 FWFT mode
  logic          b_flush, b_wr, b_rd;
  logic [DW-1:0] b_din, b_dout;
  logic          b_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic [2:0]    b_cnt;

  // Instance C: DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1
  logic          c_flush, c_wr, c_rd;
  logic [DW-1:0] c_din, c_dout;
  logic          c_valid, c_full, c_empty, c_afull, c_aempty, c_ovf, c_udf;
  logic [3:0]    c_cnt;

  int checks = 0;
  int errors = 0;

  qinst_fifo #(.DEPTH(5), .DATA_WIDTH(DW), .FWFT(0)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
    .rd_en(a_rd), .data_out(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_afull), .almost_empty(a_aempty), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_udf)
  );

  qinst_fifo #(.DEPTH(4), .DATA_WIDTH(DW), .FWFT(1)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
    .rd_en(b_rd), .data_out(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_afull), .almost_empty(b_aempty), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_udf)
  );

  qinst_fifo #(.DEPTH(8), .DATA_WIDTH(DW), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .wr_en(c_wr), .data_in(c_din),
    .rd_en(c_rd), .data_out(c_dout), .valid(c_valid), .full(c_full), .empty(c_empty),
    .almost_full(c_afull), .almost_empty(c_aempty), .count(c_cnt),
    .overflow(c_ovf), .underflow(c_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {a_flush, a_wr, a_rd, b_flush, b_wr, b_rd, c_flush, c_wr, c_rd} = '0;
    a_din = '0; b_din = '0; c_din = '0;
    tick();
    tick();

    // Reset values
    check("rst_a_count", 64'(a_cnt), 64'd0);
    check("rst_a_empty", 64'(a_empty), 64'd1);
    check("rst_a_aempty", 64'(a_aempty), 64'd1);
    check("rst_a_full", 64'(a_full), 64'd0);
    check("rst_a_afull", 64'(a_afull), 64'd0);
    check("rst_a_flags", 64'({a_ovf, a_udf}), 64'd0);
    check("rst_a_valid", 64'(a_valid), 64'd0);
    check("rst_a_dout", 64'(a_dout), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_b_dout", 64'(b_dout), 64'd0);
    reset = 1'b1;
    tick();

    // 1: fill DEPTH=5, overflow, drain with one-cycle latency
    for (int i = 1; i <= 5; i++) begin
      a_wr = 1'b1; a_din = DW'(i);
      tick();
      check("fill_count", 64'(a_cnt), 64'(i));
    end
    check("fill_full", 64'(a_full), 64'd1);
    a_din = DW'(6);
    tick();
    a_wr = 1'b0;
    check("ovf_set", 64'(a_ovf), 64'd1);
    check("ovf_count", 64'(a_cnt), 64'd5);
    a_rd = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("drain_data", 64'(a_dout), 64'(i));
      check("drain_valid", 64'(a_valid), 64'd1);
    end
    a_rd = 1'b0;
    tick();
    check("drain_valid_low", 64'(a_valid), 64'd0);
    check("drain_hold", 64'(a_dout), 64'd5);
    check("drain_empty", 64'(a_empty), 64'd1);
    check("drain_no_udf", 64'(a_udf), 64'd0);

    // 2: wrap indices over four rounds of 3 writes / 3 reads
    for (int r = 0; r < 4; r++) begin
      a_wr = 1'b1;
      for (int k = 0; k < 3; k++) begin
        a_din = DW'(16 * (r + 1) + k);
        tick();
      end
      a_wr = 1'b0; a_rd = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("wrap_data", 64'(a_dout), 64'(16 * (r + 1) + k));
      end
      a_rd = 1'b0;
    end
    tick();
    check("wrap_count", 64'(a_cnt), 64'd0);
    check("wrap_empty", 64'(a_empty), 64'd1);

    // 3: simultaneous read/write at count 2 and at full
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("flush_ovf_clr", 64'(a_ovf), 64'd0);
    a_wr = 1'b1; a_din = DW'('h21); tick();
    a_din = DW'('h22); tick();
    a_din = DW'('h23); a_rd = 1'b1; tick();
    a_wr = 1'b0;
    check("rw2_count", 64'(a_cnt), 64'd2);
    check("rw2_data0", 64'(a_dout), 64'h21);
    tick();
    check("rw2_data1", 64'(a_dout), 64'h22);
    tick();
    check("rw2_data2", 64'(a_dout), 64'h23);
    a_rd = 1'b0;
    a_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_din = DW'('h31 + i);
      tick();
    end
    a_din = DW'('h36); a_rd = 1'b1;
    tick();
    a_wr = 1'b0;
    check("rwf_count", 64'(a_cnt), 64'd4);
    check("rwf_ovf", 64'(a_ovf), 64'd1);
    check("rwf_data", 64'(a_dout), 64'h31);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("rwf_drain", 64'(a_dout), 64'('h31 + i));
    end
    tick();
    check("udf_set", 64'(a_udf), 64'd1);
    check("udf_valid", 64'(a_valid), 64'd0);
    a_rd = 1'b0;

    // 4: FWFT presentation, pop, underflow
    b_wr = 1'b1; b_din = DW'('hA);
    tick();
    b_wr = 1'b0;
    check("fwft_valid", 64'(b_valid), 64'd1);
    check("fwft_data", 64'(b_dout), 64'hA);
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    check("fwft_pop_valid", 64'(b_valid), 64'd0);
    check("fwft_pop_data", 64'(b_dout), 64'd0);
    b_wr = 1'b1; b_din = DW'('hB); tick();
    b_din = DW'('hC); tick();
    b_wr = 1'b0;
    check("fwft_head_b", 64'(b_dout), 64'hB);
    b_rd = 1'b1;
    tick();
    check("fwft_head_c", 64'(b_dout), 64'hC);
    tick();
    check("fwft_empty", 64'(b_empty), 64'd1);
    check("fwft_no_udf", 64'(b_udf), 64'd0);
    tick();
    b_rd = 1'b0;
    check("fwft_udf", 64'(b_udf), 64'd1);

    // 5: threshold flags on DEPTH=8
    check("thr0_aempty", 64'(c_aempty), 64'd1);
    c_wr = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      c_din = DW'(i);
      tick();
      check("thr_aempty", 64'(c_aempty), (i <= 1) ? 64'd1 : 64'd0);
      check("thr_afull", 64'(c_afull), (i >= 6) ? 64'd1 : 64'd0);
    end
    c_wr = 1'b0; c_rd = 1'b1;
    tick();
    c_rd = 1'b0;
    check("thr5_count", 64'(c_cnt), 64'd5);
    check("thr5_afull", 64'(c_afull), 64'd0);

    // 6: flush beats a same-cycle write and clears sticky flags
    a_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = DW'('h41 + i);
      tick();
    end
    check("pre_flush_count", 64'(a_cnt), 64'd3);
    a_din = DW'('h44); a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_wr = 1'b0;
    check("flush_count", 64'(a_cnt), 64'd0);
    check("flush_empty", 64'(a_empty), 64'd1);
    check("flush_flags", 64'({a_ovf, a_udf}), 64'd0);
    tick();
    check("flush_no_write", 64'(a_cnt), 64'd0);

    // Asynchronous reset mid-operation
    a_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_din = DW'('h51 + i);
      tick();
    end
    a_wr = 1'b0; a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    check("pre_rst_count", 64'(a_cnt), 64'd4);
    check("pre_rst_data", 64'(a_dout), 64'h51);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 64'(a_cnt), 64'd0);
    check("arst_empty", 64'(a_empty), 64'd1);
    check("arst_full", 64'(a_full), 64'd0);
    check("arst_valid", 64'(a_valid), 64'd0);
    check("arst_dout", 64'(a_dout), 64'd0);
    tick();
    reset = 1'b1;
    a_wr = 1'b1; a_din = DW'('h61);
    tick();
    a_wr = 1'b0;
    check("post_rst_count", 64'(a_cnt), 64'd1);
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    check("post_rst_data", 64'(a_dout), 64'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
